// File: rtl/of_arb_pkg.sv
// Shared types and helpers for the optical-flow result readout path.
//   idx_bits(n) : index width for n requesters, never less than 1
//   frame_t     : frame sequence number at the default width
//   ovf_t       : overwrite counter at the default width
//   of_entry_t  : one serialized result {region, dx, dy, frame}
package of_arb_pkg;

    localparam int unsigned REGIONS_MAX = 16;
    localparam int unsigned ENTRY_IDX_W = 4;
    localparam int unsigned DX_W        = 32;
    localparam int unsigned DY_W        = 32;
    localparam int unsigned FRAME_W     = 16;
    localparam int unsigned OVF_W       = 16;

    function automatic int unsigned idx_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef logic [FRAME_W-1:0] frame_t;
    typedef logic [OVF_W-1:0]   ovf_t;

    typedef struct packed {
        logic [ENTRY_IDX_W-1:0]  region;
        logic signed [DX_W-1:0]  dx;
        logic signed [DY_W-1:0]  dy;
        frame_t                  frame;
    } of_entry_t;

endpackage

// File: rtl/of_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
//   req         : request vector
//   ptr         : starting index for the search (must be < N)
//   grant_oh_c  : one-hot grant
//   grant_idx_c : grant index
//   any_c       : at least one request present
module of_rr_arbiter
    import of_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_oh_c,
    output logic [IW-1:0] grant_idx_c,
    output logic          any_c
);

    int unsigned j;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        grant_oh_c  = '0;
        grant_idx_c = '0;
        any_c       = 1'b0;
        j           = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!any_c && req[j]) begin
                grant_oh_c[j] = 1'b1;
                grant_idx_c   = IW'(j);
                any_c         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/of_result_arbiter.sv
// Buffers one LK optical-flow result per region and serializes them onto a
// valid/ready stream, tagged with region index and capture-time frame number.
//   aclk, aresetn       : clock, async active-low reset
//   in_clear            : sync clear of slots, counters, pointer, done mask
//   in_frame_start      : frame start pulse (advances frame counter)
//   s_of_dx/dy/valid    : per-region result inputs
//   m_region/dx/dy/frame, m_valid, m_ready : output stream
//   out_ovf_count       : saturating count of overwritten pending results
//   out_irq             : one-cycle pulse when every region delivered this frame
module of_result_arbiter
    import of_arb_pkg::*;
#(
    parameter  int unsigned REGIONS    = 4,
    parameter  int unsigned DX_BITS    = DX_W,
    parameter  int unsigned DY_BITS    = DY_W,
    parameter  int unsigned FRAME_BITS = FRAME_W,
    parameter  int unsigned OVF_BITS   = OVF_W,
    localparam int unsigned IDX_BITS   = idx_bits(REGIONS)
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              in_clear,
    input  logic                              in_frame_start,
    input  logic [REGIONS-1:0][DX_BITS-1:0]   s_of_dx,
    input  logic [REGIONS-1:0][DY_BITS-1:0]   s_of_dy,
    input  logic [REGIONS-1:0]                s_of_valid,
    output logic [IDX_BITS-1:0]               m_region,
    output logic [DX_BITS-1:0]                m_dx,
    output logic [DY_BITS-1:0]                m_dy,
    output logic [FRAME_BITS-1:0]             m_frame,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [OVF_BITS-1:0]               out_ovf_count,
    output logic                              out_irq
);

    logic [REGIONS-1:0]                  pending_q, pending_d;
    logic [REGIONS-1:0][DX_BITS-1:0]     slot_dx_q, slot_dx_d;
    logic [REGIONS-1:0][DY_BITS-1:0]     slot_dy_q, slot_dy_d;
    logic [REGIONS-1:0][FRAME_BITS-1:0]  slot_frame_q, slot_frame_d;
    logic [IDX_BITS-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [FRAME_BITS-1:0]               frame_cnt_q, frame_cnt_d;
    logic [REGIONS-1:0]                  done_q, done_d;

    logic [IDX_BITS-1:0]                 m_region_d;
    logic [DX_BITS-1:0]                  m_dx_d;
    logic [DY_BITS-1:0]                  m_dy_d;
    logic [FRAME_BITS-1:0]               m_frame_d;
    logic                                m_valid_d;
    logic [OVF_BITS-1:0]                 ovf_d;
    logic                                irq_d;

    logic [REGIONS-1:0]                  grant_oh;
    logic [IDX_BITS-1:0]                 grant_idx;
    logic                                grant_any;
    logic                                load_en;
    logic                                fire;
    logic                                accept;
    int unsigned                         n_ovf;
    logic [OVF_BITS:0]                   ovf_sum;

    of_rr_arbiter #(.N(REGIONS)) u_rr (
        .req         (pending_q),
        .ptr         (rr_ptr_q),
        .grant_oh_c  (grant_oh),
        .grant_idx_c (grant_idx),
        .any_c       (grant_any)
    );

    // Next-state logic for slots, output register, counters and done mask.
    always_comb begin
        pending_d    = pending_q;
        slot_dx_d    = slot_dx_q;
        slot_dy_d    = slot_dy_q;
        slot_frame_d = slot_frame_q;
        rr_ptr_d     = rr_ptr_q;
        frame_cnt_d  = frame_cnt_q;
        done_d       = done_q;
        m_region_d   = m_region;
        m_dx_d       = m_dx;
        m_dy_d       = m_dy;
        m_frame_d    = m_frame;
        m_valid_d    = m_valid;
        ovf_d        = out_ovf_count;
        irq_d        = 1'b0;
        n_ovf        = 0;
        ovf_sum      = '0;

        load_en = !m_valid || m_ready;
        fire    = load_en && grant_any;
        accept  = m_valid && m_ready;

        // A capture racing its own grant is not an overwrite: old data leaves.
        for (int unsigned i = 0; i < REGIONS; i++) begin
            if (s_of_valid[i]) begin
                slot_dx_d[i]    = s_of_dx[i];
                slot_dy_d[i]    = s_of_dy[i];
                slot_frame_d[i] = frame_cnt_q;
                pending_d[i]    = 1'b1;
                if (pending_q[i] && !(fire && grant_oh[i])) begin
                    n_ovf = n_ovf + 1;
                end
            end else if (fire && grant_oh[i]) begin
                pending_d[i] = 1'b0;
            end
        end

        ovf_sum = {1'b0, out_ovf_count} + (OVF_BITS+1)'(n_ovf);
        ovf_d   = ovf_sum[OVF_BITS] ? '1 : ovf_sum[OVF_BITS-1:0];

        if (in_frame_start) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        if (fire) begin
            m_valid_d  = 1'b1;
            m_region_d = grant_idx;
            m_dx_d     = slot_dx_q[grant_idx];
            m_dy_d     = slot_dy_q[grant_idx];
            m_frame_d  = slot_frame_q[grant_idx];
            rr_ptr_d   = (grant_idx == IDX_BITS'(REGIONS - 1)) ? '0 : grant_idx + 1'b1;
        end else if (accept) begin
            m_valid_d = 1'b0;
        end

        // Frame start wipes the mask first so a same-cycle acceptance survives.
        if (in_frame_start) begin
            done_d = '0;
        end
        if (accept) begin
            done_d[m_region] = 1'b1;
        end
        irq_d = (&done_d) && (in_frame_start || !(&done_q));

        if (in_clear) begin
            pending_d   = '0;
            m_valid_d   = 1'b0;
            rr_ptr_d    = '0;
            done_d      = '0;
            ovf_d       = '0;
            frame_cnt_d = '0;
            irq_d       = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pending_q     <= '0;
            slot_dx_q     <= '0;
            slot_dy_q     <= '0;
            slot_frame_q  <= '0;
            rr_ptr_q      <= '0;
            frame_cnt_q   <= '0;
            done_q        <= '0;
            m_region      <= '0;
            m_dx          <= '0;
            m_dy          <= '0;
            m_frame       <= '0;
            m_valid       <= 1'b0;
            out_ovf_count <= '0;
            out_irq       <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            slot_dx_q     <= slot_dx_d;
            slot_dy_q     <= slot_dy_d;
            slot_frame_q  <= slot_frame_d;
            rr_ptr_q      <= rr_ptr_d;
            frame_cnt_q   <= frame_cnt_d;
            done_q        <= done_d;
            m_region      <= m_region_d;
            m_dx          <= m_dx_d;
            m_dy          <= m_dy_d;
            m_frame       <= m_frame_d;
            m_valid       <= m_valid_d;
            out_ovf_count <= ovf_d;
            out_irq       <= irq_d;
        end
    end

endmodule
